// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer.
package reset_sequencer_pkg;

  localparam int unsigned DEF_N_DOMAINS   = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 1024;
  localparam int unsigned DEF_STAGE_GAP   = 16;

  // One counter covers both lock qualification (up to 65535) and stage gaps.
  localparam int unsigned CNT_W = 16;
  // Domain index width, enough for up to 8 domains.
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } state_e;

endpackage

// File: rtl/reset_sequencer_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives the clean level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release after PLL lock qualification, with software re-sequencing.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned N_DOMAINS   = DEF_N_DOMAINS,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 soft_req,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 ready,
  output logic                 soft_ack
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 soft_seq_q, soft_seq_d;
  logic [N_DOMAINS-1:0] rst_d;
  logic                 ready_d;
  logic                 ack_d;
  logic                 lock_s;
  logic                 lock_last;
  logic                 gap_last;
  logic                 idx_last;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign lock_last = (cnt_q == CNT_W'(LOCK_CYCLES - 1));
  assign gap_last  = (cnt_q == CNT_W'(STAGE_GAP - 1));
  assign idx_last  = (idx_q == IDX_W'(N_DOMAINS - 1));

  // State, sequencing counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAIT_LOCK;
      cnt_q      <= '0;
      idx_q      <= '0;
      soft_seq_q <= 1'b0;
      rst_out    <= '1;
      ready      <= 1'b0;
      soft_ack   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      soft_seq_q <= soft_seq_d;
      rst_out    <= rst_d;
      ready      <= ready_d;
      soft_ack   <= ack_d;
    end
  end

  // Next state; lock loss overrides every other event.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    soft_seq_d = soft_seq_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_STABLE: begin
        if (lock_last) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (gap_last) begin
          cnt_d = '0;
          if (idx_last) begin
            state_d    = ST_RUN;
            idx_d      = '0;
            soft_seq_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (soft_req && !soft_ack) begin
          state_d    = ST_SOFT;
          cnt_d      = '0;
          soft_seq_d = 1'b1;
        end
      end
      ST_SOFT: begin
        if (gap_last) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        cnt_d      = '0;
        idx_d      = '0;
        soft_seq_d = 1'b0;
      end
    endcase
    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      state_d    = ST_WAIT_LOCK;
      cnt_d      = '0;
      idx_d      = '0;
      soft_seq_d = 1'b0;
    end
  end

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    rst_d   = rst_out;
    ready_d = 1'b0;
    ack_d   = 1'b0;
    case (state_d)
      ST_RELEASE: begin
        if (state_q != ST_RELEASE) begin
          rst_d = '1;
        end else if (gap_last) begin
          for (int unsigned i = 0; i < N_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              rst_d[i] = 1'b0;
            end
          end
        end
      end
      ST_RUN: begin
        rst_d   = '0;
        ready_d = 1'b1;
        ack_d   = (state_q == ST_RELEASE) && soft_seq_q;
      end
      default: begin
        rst_d = '1;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: timestamp-based reference model plus directed timing checks.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int LOCK = 8;
  localparam int GAP  = 4;

  logic         clk;
  logic         reset;
  logic         pll_locked;
  logic         soft_req;
  logic [N-1:0] rst_out;
  logic         ready;
  logic         soft_ack;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .N_DOMAINS   (N),
    .LOCK_CYCLES (LOCK),
    .STAGE_GAP   (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .soft_req   (soft_req),
    .rst_out    (rst_out),
    .ready      (ready),
    .soft_ack   (soft_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is a start edge plus a kind (lock or soft);
  // every output follows from elapsed edges since that start.
  logic         h1 = 1'b0;
  logic         h2 = 1'b0;
  logic         m_lk;
  bit           m_active = 1'b0;
  bit           m_soft = 1'b0;
  int           m_e = 0;
  int           m_t0 = 0;
  int           m_k;
  int           m_base;
  logic [N-1:0] m_rst = '1;
  logic         m_ready = 1'b0;
  logic         m_ack = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      h1 = 1'b0; h2 = 1'b0;
      m_active = 1'b0; m_soft = 1'b0;
      m_rst = '1; m_ready = 1'b0; m_ack = 1'b0;
    end else begin
      m_lk = h2;          // lock level as seen two edges after sampling
      h2 = h1;
      h1 = pll_locked;
      m_e++;
      if (!m_lk) begin
        m_active = 1'b0;
        m_soft   = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_soft   = 1'b0;
        m_t0     = m_e;
      end else if (m_ready && soft_req && !m_ack) begin
        m_soft = 1'b1;
        m_t0   = m_e;
      end
      if (!m_active) begin
        m_rst = '1; m_ready = 1'b0; m_ack = 1'b0;
      end else begin
        m_k    = m_e - m_t0;
        m_base = m_soft ? GAP : LOCK;
        for (int i = 0; i < N; i++) m_rst[i] = !(m_k >= m_base + (i + 1) * GAP);
        m_ready = (m_k >= m_base + N * GAP);
        m_ack   = m_soft && (m_k == m_base + N * GAP);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_rst_out", 32'(rst_out), 32'({N{1'b1}}));
      chk("model_ready", 32'(ready), 32'(0));
      chk("model_soft_ack", 32'(soft_ack), 32'(0));
    end else begin
      chk("model_rst_out", 32'(rst_out), 32'(m_rst));
      chk("model_ready", 32'(ready), 32'(m_ready));
      chk("model_soft_ack", 32'(soft_ack), 32'(m_ack));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Called just after edge T, the edge after which pll_locked went high.
  task automatic pu_checks(input string tag);
    ticks(14); chk({tag, "_t14_rst"}, 32'(rst_out), 32'(3'b111));
    ticks(1);  chk({tag, "_t15_rst"}, 32'(rst_out), 32'(3'b110));
    ticks(3);  chk({tag, "_t18_rst"}, 32'(rst_out), 32'(3'b110));
    ticks(1);  chk({tag, "_t19_rst"}, 32'(rst_out), 32'(3'b100));
    ticks(3);  chk({tag, "_t22_rst"}, 32'(rst_out), 32'(3'b100));
               chk({tag, "_t22_ready"}, 32'(ready), 32'(0));
    ticks(1);  chk({tag, "_t23_rst"}, 32'(rst_out), 32'(3'b000));
               chk({tag, "_t23_ready"}, 32'(ready), 32'(1));
               chk({tag, "_t23_ack"}, 32'(soft_ack), 32'(0));
  endtask

  initial begin
    reset = 1'b0; pll_locked = 1'b0; soft_req = 1'b0;
    ticks(3);
    chk("reset_rst_out", 32'(rst_out), 32'(3'b111));
    chk("reset_ready", 32'(ready), 32'(0));
    chk("reset_ack", 32'(soft_ack), 32'(0));
    reset = 1'b1;
    ticks(3);
    chk("wait_lock_rst_out", 32'(rst_out), 32'(3'b111));

    // Power-up sequence
    tick(); pll_locked = 1'b1;
    pu_checks("pu");
    ticks(5);
    chk("run_hold_ready", 32'(ready), 32'(1));
    chk("run_hold_ack", 32'(soft_ack), 32'(0));

    // Soft reset; a request during the ack cycle is ignored
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    chk("soft_q0_rst", 32'(rst_out), 32'(3'b111));
    chk("soft_q0_ready", 32'(ready), 32'(0));
    ticks(7);  chk("soft_q7_rst", 32'(rst_out), 32'(3'b111));
    ticks(1);  chk("soft_q8_rst", 32'(rst_out), 32'(3'b110));
    ticks(4);  chk("soft_q12_rst", 32'(rst_out), 32'(3'b100));
    ticks(3);  chk("soft_q15_ack", 32'(soft_ack), 32'(0));
    ticks(1);  chk("soft_q16_rst", 32'(rst_out), 32'(3'b000));
               chk("soft_q16_ready", 32'(ready), 32'(1));
               chk("soft_q16_ack", 32'(soft_ack), 32'(1));
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    chk("soft_q17_ack", 32'(soft_ack), 32'(0));
    chk("soft_q17_ready", 32'(ready), 32'(1));
    tick();
    chk("soft_q18_rst", 32'(rst_out), 32'(3'b000));

    // Lock glitch during qualification
    pll_locked = 1'b0; ticks(4);
    chk("drop_rst", 32'(rst_out), 32'(3'b111));
    chk("drop_ready", 32'(ready), 32'(0));
    ticks(2);
    tick(); pll_locked = 1'b1;
    ticks(6); pll_locked = 1'b0;
    tick();   pll_locked = 1'b1;
    ticks(8); chk("glitch_t15_rst", 32'(rst_out), 32'(3'b111));
    ticks(6); chk("glitch_t21_rst", 32'(rst_out), 32'(3'b111));
    ticks(1); chk("glitch_t22_rst", 32'(rst_out), 32'(3'b110));
    ticks(7); chk("glitch_t29_ready", 32'(ready), 32'(0));
    ticks(1); chk("glitch_t30_ready", 32'(ready), 32'(1));
              chk("glitch_t30_ack", 32'(soft_ack), 32'(0));

    // Lock loss right after the first domain releases
    pll_locked = 1'b0; ticks(5);
    tick(); pll_locked = 1'b1;
    ticks(15); chk("rel_loss_t15_rst", 32'(rst_out), 32'(3'b110));
    pll_locked = 1'b0;
    ticks(2); chk("rel_loss_f2_rst", 32'(rst_out), 32'(3'b110));
    ticks(1); chk("rel_loss_f3_rst", 32'(rst_out), 32'(3'b111));
              chk("rel_loss_f3_ready", 32'(ready), 32'(0));
              chk("rel_loss_f3_ack", 32'(soft_ack), 32'(0));
    ticks(4);

    // Soft request on the same edge the synchronized lock drops
    tick(); pll_locked = 1'b1;
    ticks(23); chk("sim_run_ready", 32'(ready), 32'(1));
    ticks(2);
    pll_locked = 1'b0;
    tick(); pll_locked = 1'b1;
    tick(); soft_req = 1'b1;
    tick(); soft_req = 1'b0;
    chk("sim_f3_rst", 32'(rst_out), 32'(3'b111));
    chk("sim_f3_ready", 32'(ready), 32'(0));
    ticks(16); chk("sim_f19_ready", 32'(ready), 32'(0));
               chk("sim_f19_ack", 32'(soft_ack), 32'(0));
    ticks(5);  chk("sim_f24_ready", 32'(ready), 32'(1));
               chk("sim_f24_ack", 32'(soft_ack), 32'(0));
    ticks(1);  chk("sim_f25_ack", 32'(soft_ack), 32'(0));

    // Asynchronous reset mid-release, then the power-up timing again
    pll_locked = 1'b0; ticks(5);
    tick(); pll_locked = 1'b1;
    ticks(16); chk("ar_pre_rst", 32'(rst_out), 32'(3'b110));
    #2; reset = 1'b0;
    #1;
    chk("ar_async_rst", 32'(rst_out), 32'(3'b111));
    chk("ar_async_ready", 32'(ready), 32'(0));
    ticks(2);
    reset = 1'b1;
    pu_checks("ar");
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
